// File: rtl/dso_pkg.sv
// dso_pkg: shared state encoding, cfg field layout and trigger defaults for the DSO capture path
package dso_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMING = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_FIRE   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam int LEVEL_LSB   = 0;
  localparam int LEVEL_W     = 8;
  localparam int HYST_LSB    = 8;
  localparam int HYST_W      = 4;
  localparam int SRC_BIT     = 12;
  localparam int SLOPE_BIT   = 13;
  localparam int EN_BIT      = 14;
  localparam int AUTO_EN_BIT = 15;
  localparam int HOLDOFF_LSB = 16;
  localparam int HOLDOFF_W   = 16;
  localparam logic [23:0] AUTO_TIMEOUT_DEF = 24'd1_000_000;
  typedef struct packed {
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 auto_en;
    logic                 slope;
    logic                 src;
    logic [HYST_W-1:0]    hyst;
    logic [LEVEL_W-1:0]   level;
  } shadow_t;
  function automatic shadow_t to_shadow(input logic [31:0] c);
    return '{holdoff: c[HOLDOFF_LSB +: HOLDOFF_W], auto_en: c[AUTO_EN_BIT], slope: c[SLOPE_BIT],
             src: c[SRC_BIT], hyst: c[HYST_LSB +: HYST_W], level: c[LEVEL_LSB +: LEVEL_W]};
  endfunction
endpackage

// File: rtl/trig_compare.sv
// trig_compare: band compare giving pre-crossing (arm) and crossing (fire) conditions for one sample
module trig_compare
  import dso_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0]     sample,
  input  logic [DW-1:0]     level,
  input  logic [HYST_W-1:0] hyst,
  input  logic              slope,
  output logic              arm_ok,
  output logic              fire_ok
);
  logic [DW:0] lo, hi;
  // Band edges carry one extra bit so an out-of-range edge disables arming instead of wrapping
  always_comb begin
    lo      = {1'b0, level} - (DW+1)'(hyst);
    hi      = {1'b0, level} + (DW+1)'(hyst);
    arm_ok  = slope ? (!hi[DW] && sample > hi[DW-1:0]) : (!lo[DW] && sample < lo[DW-1:0]);
    fire_ok = slope ? (sample <= level) : (sample >= level);
  end
endmodule

// File: rtl/trigger_detect.sv
// trigger_detect: level/slope/hysteresis trigger with holdoff and auto-trigger timeout for the ADC driver
module trigger_detect
  import dso_pkg::*;
#(
  parameter int              DW           = 8,
  parameter int              HOLD_W       = 16,
  parameter int              AUTO_W       = 24,
  parameter logic [AUTO_W-1:0] AUTO_TIMEOUT = AUTO_W'(AUTO_TIMEOUT_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [DW-1:0] adc_a,
  input  logic [DW-1:0] adc_b,
  input  logic [31:0]   cfg,
  input  logic          arm,
  output logic          trigger_req,
  output logic          auto_fired,
  output logic          busy
);
  logic [2:0]        state_q, state_d;
  logic [DW-1:0]     s1_q, s1_d;
  logic              v1_q, v1_d;
  shadow_t           shadow_q, shadow_d;
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              auto_fired_q, auto_fired_d;
  logic              src, timeout, arm_ok, fire_ok;

  trig_compare #(.DW(DW)) u_cmp (
    .sample (s1_q),
    .level  (DW'(shadow_q.level)),
    .hyst   (shadow_q.hyst),
    .slope  (shadow_q.slope),
    .arm_ok (arm_ok),
    .fire_ok(fire_ok)
  );

  // Before the shadow is loaded the live cfg picks the channel, so the first sample after arming is correct
  always_comb begin
    src  = (state_q == ST_IDLE) ? cfg[SRC_BIT] : shadow_q.src;
    s1_d = sample_en ? (src ? adc_b : adc_a) : s1_q;
    v1_d = sample_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s1_q         <= '0;
      v1_q         <= 1'b0;
      shadow_q     <= '0;
      auto_cnt_q   <= '0;
      hold_q       <= '0;
      auto_fired_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      v1_q         <= v1_d;
      shadow_q     <= shadow_d;
      auto_cnt_q   <= auto_cnt_d;
      hold_q       <= hold_d;
      auto_fired_q <= auto_fired_d;
    end
  end

  // A real crossing takes priority over a timeout on the same sample
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    auto_cnt_d   = auto_cnt_q;
    hold_d       = hold_q;
    auto_fired_d = auto_fired_q;
    timeout      = shadow_q.auto_en && (auto_cnt_q == AUTO_TIMEOUT - AUTO_W'(1));
    case (state_q)
      ST_IDLE: if (arm && cfg[EN_BIT]) begin
        shadow_d   = to_shadow(cfg);
        auto_cnt_d = '0;
        state_d    = ST_ARMING;
      end
      ST_ARMING, ST_WAIT: if (!arm) state_d = ST_IDLE;
      else if (v1_q) begin
        auto_cnt_d = (shadow_q.auto_en && !timeout) ? auto_cnt_q + 1'b1 : auto_cnt_q;
        if (state_q == ST_WAIT && fire_ok) begin
          state_d      = ST_FIRE;
          auto_fired_d = 1'b0;
        end else if (timeout) begin
          state_d      = ST_FIRE;
          auto_fired_d = 1'b1;
        end else if (state_q == ST_ARMING && arm_ok) state_d = ST_WAIT;
      end
      ST_FIRE: if (!arm) begin
        hold_d  = HOLD_W'(shadow_q.holdoff);
        state_d = ST_HOLD;
      end
      ST_HOLD: if (hold_q == '0) state_d = ST_IDLE;
      else if (v1_q) hold_d = hold_q - 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trigger_req = (state_q == ST_FIRE);
    busy        = (state_q != ST_IDLE);
    auto_fired  = auto_fired_q;
  end
endmodule
